// File: rtl/cs_pkg.sv
// Shared types and helpers for the carry-save resolver.
package cs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SUB,
    DECIDE,
    DONE
  } state_t;

  // Number of W-bit chunks in an N-bit operand.
  function automatic int unsigned nc(input int unsigned n, input int unsigned w);
    return n / w;
  endfunction

  // True when N splits evenly into W-bit chunks.
  function automatic bit chunks_ok(input int unsigned n, input int unsigned w);
    return (w != 0) && ((n % w) == 0);
  endfunction

endpackage

// File: rtl/cs_chunk_alu.sv
// W-bit add/subtract slice shared by the add and trial-subtract passes.
// In subtract mode cin/cout are borrow-in/borrow-out.
module cs_chunk_alu #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         cout
);

  logic [W-1:0] b_eff;
  logic         c_eff;
  logic         c_raw;

  // Subtraction is a + ~b + ~borrow on the single adder; carry inverts to borrow.
  always_comb begin
    b_eff        = sub ? ~b : b;
    c_eff        = sub ? ~cin : cin;
    {c_raw, y}   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, c_eff};
    cout         = sub ? ~c_raw : c_raw;
  end

endmodule

// File: rtl/cs_resolver.sv
// Resolves a carry-save pair (p, q) into the canonical residue (p + q) mod n,
// one W-bit chunk per cycle: a chunked add, then chunked trial subtractions.
module cs_resolver
  import cs_pkg::*;
#(
  parameter int unsigned N       = 1 << 16,
  parameter int unsigned W       = 64,
  parameter int unsigned MAX_SUB = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:0]   p,
  input  logic [N:0]   q,
  input  logic [N-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] r,
  output logic         err,
  output logic [1:0]   nsub
);

  localparam int unsigned NC = nc(N, W);
  localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;

  if (!chunks_ok(N, W)) begin : g_bad_chunking
    $error("cs_resolver: N must be a multiple of W");
  end

  state_t         state;
  logic [N:0]     pr;
  logic [N:0]     qr;
  logic [N-1:0]   nr;
  logic [N:0]     s;
  logic [N:0]     d;
  logic [IW-1:0]  idx;
  logic           cy;
  logic           fb;

  logic [W-1:0]   a_chunk;
  logic [W-1:0]   b_chunk;
  logic [W-1:0]   y_chunk;
  logic           alu_cout;
  logic           alu_sub;
  logic           last;

  // Route the current chunk of the active pass into the shared ALU.
  always_comb begin
    alu_sub = (state == SUB);
    last    = (idx == IW'(NC - 1));
    if (alu_sub) begin
      a_chunk = s[idx*W +: W];
      b_chunk = nr[idx*W +: W];
    end else begin
      a_chunk = pr[idx*W +: W];
      b_chunk = qr[idx*W +: W];
    end
  end

  cs_chunk_alu #(.W(W)) u_alu (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (cy),
    .sub  (alu_sub),
    .y    (y_chunk),
    .cout (alu_cout)
  );

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      err       <= 1'b0;
      nsub      <= '0;
      idx       <= '0;
      cy        <= 1'b0;
      fb        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            pr       <= p;
            qr       <= q;
            nr       <= n;
            cy       <= 1'b0;
            idx      <= '0;
            nsub     <= '0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end

        ADD: begin
          s[idx*W +: W] <= y_chunk;
          if (last) begin
            // Bit N wraps: the caller guarantees p + q < 2^(N+1).
            s[N]  <= pr[N] ^ qr[N] ^ alu_cout;
            cy    <= 1'b0;
            idx   <= '0;
            state <= SUB;
          end else begin
            cy  <= alu_cout;
            idx <= idx + 1'b1;
          end
        end

        SUB: begin
          d[idx*W +: W] <= y_chunk;
          if (last) begin
            d[N]  <= s[N] ^ alu_cout;
            fb    <= ~s[N] & alu_cout;
            cy    <= 1'b0;
            idx   <= '0;
            state <= DECIDE;
          end else begin
            cy  <= alu_cout;
            idx <= idx + 1'b1;
          end
        end

        DECIDE: begin
          if (fb) begin
            r         <= s[N-1:0];
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (nsub < 2'(MAX_SUB)) begin
            s     <= d;
            nsub  <= nsub + 1'b1;
            cy    <= 1'b0;
            idx   <= '0;
            state <= SUB;
          end else begin
            r         <= s[N-1:0];
            err       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_resolver.sv
// Directed bench for cs_resolver at N=16, W=4 with a cycle-level reference model.
module tb_cs_resolver;

  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB:0]   p_i;
  logic [NB:0]   q_i;
  logic [NB-1:0] n_i;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] r;
  logic          err;
  logic [1:0]    nsub;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // reference model state
  bit        m_idle = 1'b1;
  bit        exp_valid = 1'b0;
  int        exp_r = 0;
  int        exp_err = 0;
  int        exp_nsub = 0;
  bit        nsub_known = 1'b1;
  int        cnt = 0;
  int        pend_r, pend_err, pend_nsub, pend_lat;

  cs_resolver #(.N(16), .W(4), .MAX_SUB(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p_i),
    .q         (q_i),
    .n         (n_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .err       (err),
    .nsub      (nsub)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  // Residue by repeated subtraction of n from the wrapped sum, capped at 3.
  function automatic void model(input int pp, input int qq, input int nn,
                                output int rr, output int e, output int k, output int lat);
    int sum;
    sum = (pp + qq) % 131072;
    k = 0;
    while (sum >= nn && k < 3) begin
      sum = sum - nn;
      k++;
    end
    e   = (sum >= nn) ? 1 : 0;
    rr  = sum % 65536;
    lat = 4 + (k + 1) * 5;
  endfunction

  // Model advances on the same edges as the DUT, from bench-driven inputs only.
  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; exp_valid = 1'b0; exp_r = 0; exp_err = 0; exp_nsub = 0;
      nsub_known = 1'b1; cnt = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        model(int'(p_i), int'(q_i), int'(n_i), pend_r, pend_err, pend_nsub, pend_lat);
        m_idle = 1'b0; cnt = pend_lat; nsub_known = 1'b0;
      end
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        exp_valid = 1'b1; exp_r = pend_r; exp_err = pend_err; exp_nsub = pend_nsub;
        nsub_known = 1'b1;
      end
    end else if (exp_valid && out_ready) begin
      exp_valid = 1'b0; m_idle = 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_in_ready", int'(in_ready), int'(m_idle));
      check("cyc_out_valid", int'(out_valid), int'(exp_valid));
      check("cyc_r", int'(r), exp_r);
      check("cyc_err", int'(err), exp_err);
      if (nsub_known) check("cyc_nsub", int'(nsub), exp_nsub);
    end
  end

  task automatic start(input int pp, input int qq, input int nn);
    @(negedge clk);
    p_i = 17'(pp); q_i = 17'(qq); n_i = 16'(nn); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; leaves the caller on a negedge.
  task automatic wait_result(input string tag, input int er, input int ee, input int ek, input int el);
    int cyc = 0;
    bit got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check({tag, "_latency"}, cyc, el);
    check({tag, "_r"}, int'(r), er);
    check({tag, "_err"}, int'(err), ee);
    check({tag, "_nsub"}, int'(nsub), ek);
  endtask

  task automatic release_out(input string tag, input int er, input int ee, input int hold);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold_r"}, int'(r), er);
      check({tag, "_hold_err"}, int'(err), ee);
      check({tag, "_hold_in_ready"}, int'(in_ready), 0);
      check({tag, "_hold_valid"}, int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    p_i = '0; q_i = '0; n_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_r", int'(r), 0);
    chk_en = 1'b1;

    start(32'h00010, 32'h00005, 32'hFFF1);
    wait_result("v1", 32'h0015, 0, 0, 9);
    release_out("v1", 32'h0015, 0, 0);

    start(32'h0FFF0, 32'h00010, 32'hFFF1);
    wait_result("v2", 32'h000F, 0, 1, 14);
    release_out("v2", 32'h000F, 0, 0);

    start(32'h0C000, 32'h0C003, 32'h8001);
    wait_result("v3", 32'h0000, 0, 3, 24);
    release_out("v3", 32'h0000, 0, 1);

    start(32'h00005, 32'h00000, 32'h0001);
    wait_result("viol", 32'h0002, 1, 3, 24);
    release_out("viol", 32'h0002, 1, 0);

    start(32'h00000, 32'h00000, 32'hFFF1);
    wait_result("zero", 32'h0000, 0, 0, 9);
    release_out("zero", 32'h0000, 0, 0);

    start(32'h04800, 32'h04800, 32'h9000);
    wait_result("eqn", 32'h0000, 0, 1, 14);
    release_out("eqn", 32'h0000, 0, 0);

    start(32'h1FFFF, 32'h00000, 32'h8000);
    wait_result("max", 32'h7FFF, 0, 3, 24);
    release_out("max", 32'h7FFF, 0, 0);

    // Backpressure with a second request held pending the whole time.
    start(32'h00010, 32'h00005, 32'hFFF1);
    p_i = 17'h00123; q_i = 17'h00456; in_valid = 1'b1;
    wait_result("bp1", 32'h0015, 0, 0, 9);
    release_out("bp1", 32'h0015, 0, 5);
    @(negedge clk);
    check("bp_idle_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_taken", int'(in_ready), 0);
    @(posedge clk); #1;
    wait_result("bp2", 32'h0579, 0, 0, 8);
    release_out("bp2", 32'h0579, 0, 0);

    // Reset at chunk 2 of the first subtraction pass.
    start(32'h0FFF0, 32'h00010, 32'hFFF1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_r", int'(r), 0);
    check("rst_err", int'(err), 0);
    check("rst_nsub", int'(nsub), 0);

    start(32'h0FFF0, 32'h00010, 32'hFFF1);
    wait_result("post_rst", 32'h000F, 0, 1, 14);
    release_out("post_rst", 32'h000F, 0, 0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
